// File: rtl/mips_pipe_pkg.sv
// Shared types and constants for the MIPS-style ID/EX pipeline slice.
// Contents: datapath/register widths, ALU opcode constants, forward-select
// enum, EX-stage register payload struct and a RAW-match helper.
package mips_pipe_pkg;

   localparam int unsigned DW  = 32;   // datapath width
   localparam int unsigned RW  = 5;    // register-number width
   localparam int unsigned AW  = 4;    // ALU opcode width
   localparam int unsigned SAW = 5;    // shift-amount width

   localparam logic [AW-1:0] ALUC_ADD  = 4'b0000;
   localparam logic [AW-1:0] ALUC_SUB  = 4'b0100;
   localparam logic [AW-1:0] ALUC_AND  = 4'b0001;
   localparam logic [AW-1:0] ALUC_OR   = 4'b0101;
   localparam logic [AW-1:0] ALUC_XOR  = 4'b0010;
   localparam logic [AW-1:0] ALUC_LUI  = 4'b0110;
   localparam logic [AW-1:0] ALUC_HAMD = 4'b1001;
   localparam logic [AW-1:0] ALUC_SLL  = 4'b0011;
   localparam logic [AW-1:0] ALUC_SRL  = 4'b0111;
   localparam logic [AW-1:0] ALUC_SRA  = 4'b1111;

   typedef enum logic [1:0] {
      FWD_RF  = 2'd0,
      FWD_EX  = 2'd1,
      FWD_MEM = 2'd2
   } fwd_sel_e;

   // Contents of the ID/EX pipeline register
   typedef struct packed {
      logic          valid;
      logic          wreg;
      logic          m2reg;
      logic          wmem;
      logic [AW-1:0] aluc;
      logic [RW-1:0] rn;
      logic [DW-1:0] a;
      logic [DW-1:0] b;
      logic [DW-1:0] store;
   } ex_bundle_t;

   // A producer writing dst matches source src; r0 never matches
   function automatic logic raw_match(input logic          wr,
                                      input logic [RW-1:0] dst,
                                      input logic [RW-1:0] src);
      return wr & (dst != '0) & (dst == src);
   endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// Bundle of ID-side inputs, EX/MEM feedback and EX-stage outputs of id_ex_stage.
// master: ID/EX/MEM environment side (drives id_*, flush, ex_result, mem_*).
// slave : the id_ex_stage block (drives stall and the e* EX-stage outputs).
interface id_ex_stage_if;
   import mips_pipe_pkg::*;

   logic            id_valid;
   logic [DW-1:0]   id_qa;
   logic [DW-1:0]   id_qb;
   logic [RW-1:0]   id_rs;
   logic [RW-1:0]   id_rt;
   logic            id_use_rs;
   logic            id_use_rt;
   logic [DW-1:0]   id_imm;
   logic [SAW-1:0]  id_sa;
   logic            id_shift;
   logic            id_aluimm;
   logic [AW-1:0]   id_aluc;
   logic            id_wreg;
   logic            id_m2reg;
   logic            id_wmem;
   logic [RW-1:0]   id_rn;
   logic            flush;
   logic [DW-1:0]   ex_result;
   logic            mem_wreg;
   logic [RW-1:0]   mem_rn;
   logic [DW-1:0]   mem_wdata;

   logic            stall;
   logic            evalid;
   logic            ewreg;
   logic            em2reg;
   logic            ewmem;
   logic [DW-1:0]   ea;
   logic [DW-1:0]   eb;
   logic [AW-1:0]   ealuc;
   logic [RW-1:0]   ern;
   logic [DW-1:0]   estore;

   modport master (
      output id_valid, id_qa, id_qb, id_rs, id_rt, id_use_rs, id_use_rt,
             id_imm, id_sa, id_shift, id_aluimm, id_aluc, id_wreg, id_m2reg,
             id_wmem, id_rn, flush, ex_result, mem_wreg, mem_rn, mem_wdata,
      input  stall, evalid, ewreg, em2reg, ewmem, ea, eb, ealuc, ern, estore
   );

   modport slave (
      input  id_valid, id_qa, id_qb, id_rs, id_rt, id_use_rs, id_use_rt,
             id_imm, id_sa, id_shift, id_aluimm, id_aluc, id_wreg, id_m2reg,
             id_wmem, id_rn, flush, ex_result, mem_wreg, mem_rn, mem_wdata,
      output stall, evalid, ewreg, em2reg, ewmem, ea, eb, ealuc, ern, estore
   );

endinterface

// File: rtl/id_ex_fwd_unit.sv
// Combinational operand forwarding and hazard/stall detection for ID/EX.
// Ports: i_id_* ID fields; i_e* current EX-stage register contents;
//        i_mem_* MEM-stage write-back info; o_fwd_a/o_fwd_b resolved rs/rt
//        values; o_stall_c combinational stall to PC and IF/ID.
// Build option: FWD_EN defined -> EX/MEM bypass with load-use stall only;
//               FWD_EN undefined -> no bypass, stall on any EX/MEM RAW match.
module id_ex_fwd_unit
   import mips_pipe_pkg::*;
(
   input  logic          i_id_valid,
   input  logic [RW-1:0] i_id_rs,
   input  logic [RW-1:0] i_id_rt,
   input  logic          i_use_rs,
   input  logic          i_use_rt,
   input  logic [DW-1:0] i_qa,
   input  logic [DW-1:0] i_qb,
   input  logic          i_flush,
   input  logic          i_evalid,
   input  logic          i_ewreg,
   input  logic          i_em2reg,
   input  logic [RW-1:0] i_ern,
   input  logic [DW-1:0] i_ex_result,
   input  logic          i_mem_wreg,
   input  logic [RW-1:0] i_mem_rn,
   input  logic [DW-1:0] i_mem_wdata,
   output logic [DW-1:0] o_fwd_a,
   output logic [DW-1:0] o_fwd_b,
   output logic          o_stall_c
);

   logic w_ex_rs;
   logic w_ex_rt;
   logic w_mem_rs;
   logic w_mem_rt;
   logic w_hazard;

   // RAW matches against the EX and MEM producers
   assign w_ex_rs  = raw_match(i_evalid & i_ewreg, i_ern, i_id_rs);
   assign w_ex_rt  = raw_match(i_evalid & i_ewreg, i_ern, i_id_rt);
   assign w_mem_rs = raw_match(i_mem_wreg, i_mem_rn, i_id_rs);
   assign w_mem_rt = raw_match(i_mem_wreg, i_mem_rn, i_id_rt);

`ifdef FWD_EN
   fwd_sel_e w_sel_a;
   fwd_sel_e w_sel_b;

   // Youngest producer wins: EX before MEM before register file
   always_comb begin
      w_sel_a = FWD_RF;
      w_sel_b = FWD_RF;
      if (w_ex_rs)       w_sel_a = FWD_EX;
      else if (w_mem_rs) w_sel_a = FWD_MEM;
      if (w_ex_rt)       w_sel_b = FWD_EX;
      else if (w_mem_rt) w_sel_b = FWD_MEM;
   end

   // Operand muxes
   always_comb begin
      o_fwd_a = i_qa;
      o_fwd_b = i_qb;
      case (w_sel_a)
         FWD_EX:  o_fwd_a = i_ex_result;
         FWD_MEM: o_fwd_a = i_mem_wdata;
         default: o_fwd_a = i_qa;
      endcase
      case (w_sel_b)
         FWD_EX:  o_fwd_b = i_ex_result;
         FWD_MEM: o_fwd_b = i_mem_wdata;
         default: o_fwd_b = i_qb;
      endcase
   end

   // Only a load in EX cannot be bypassed: its data appears one stage later
   assign w_hazard = (i_use_rs & raw_match(i_evalid & i_em2reg, i_ern, i_id_rs))
                   | (i_use_rt & raw_match(i_evalid & i_em2reg, i_ern, i_id_rt));
`else
   logic w_unused_fwd;

   assign o_fwd_a = i_qa;
   assign o_fwd_b = i_qb;

   // Without bypass, wait until the producer has left MEM (written back)
   assign w_hazard = (i_use_rs & (w_ex_rs | w_mem_rs))
                   | (i_use_rt & (w_ex_rt | w_mem_rt));

   assign w_unused_fwd = ^{i_ex_result, i_mem_wdata, i_em2reg};
`endif

   // A squashed instruction never stalls the front end
   assign o_stall_c = i_id_valid & w_hazard & ~i_flush;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline stage feeding the 32-bit ALU (a, b, aluc).
// Ports: clock, reset (synchronous, active-high); io_pipe (id_ex_stage_if.slave)
//        carrying ID fields, flush, EX/MEM feedback, combinational stall and
//        the registered EX-stage outputs evalid/ewreg/em2reg/ewmem/ea/eb/
//        ealuc/ern/estore.
// Build option: FWD_EN enables EX/MEM operand forwarding (see id_ex_fwd_unit).
module id_ex_stage
   import mips_pipe_pkg::*;
(
   input  logic         clock,
   input  logic         reset,
   id_ex_stage_if.slave io_pipe
);

   logic [DW-1:0] w_fwd_a;
   logic [DW-1:0] w_fwd_b;
   logic          w_stall_c;
   logic          w_bubble;
   ex_bundle_t    w_next;
   ex_bundle_t    r_ex;

   id_ex_fwd_unit u_fwd (
      .i_id_valid  (io_pipe.id_valid),
      .i_id_rs     (io_pipe.id_rs),
      .i_id_rt     (io_pipe.id_rt),
      .i_use_rs    (io_pipe.id_use_rs),
      .i_use_rt    (io_pipe.id_use_rt),
      .i_qa        (io_pipe.id_qa),
      .i_qb        (io_pipe.id_qb),
      .i_flush     (io_pipe.flush),
      .i_evalid    (r_ex.valid),
      .i_ewreg     (r_ex.wreg),
      .i_em2reg    (r_ex.m2reg),
      .i_ern       (r_ex.rn),
      .i_ex_result (io_pipe.ex_result),
      .i_mem_wreg  (io_pipe.mem_wreg),
      .i_mem_rn    (io_pipe.mem_rn),
      .i_mem_wdata (io_pipe.mem_wdata),
      .o_fwd_a     (w_fwd_a),
      .o_fwd_b     (w_fwd_b),
      .o_stall_c   (w_stall_c)
   );

   // Next EX-stage contents for a real, unstalled instruction
   always_comb begin
      w_next       = '0;
      w_next.valid = 1'b1;
      w_next.wreg  = io_pipe.id_wreg;
      w_next.m2reg = io_pipe.id_m2reg;
      w_next.wmem  = io_pipe.id_wmem;
      w_next.aluc  = io_pipe.id_aluc;
      w_next.rn    = io_pipe.id_rn;
      w_next.a     = io_pipe.id_shift  ? DW'(io_pipe.id_sa) : w_fwd_a;
      w_next.b     = io_pipe.id_aluimm ? io_pipe.id_imm     : w_fwd_b;
      w_next.store = w_fwd_b;
   end

   assign w_bubble = io_pipe.flush | w_stall_c | ~io_pipe.id_valid;

   // Pipeline register; a bubble is an all-zero bundle
   always_ff @(posedge clock) begin
      if (reset)         r_ex <= '0;
      else if (w_bubble) r_ex <= '0;
      else               r_ex <= w_next;
   end

   assign io_pipe.stall  = w_stall_c;
   assign io_pipe.evalid = r_ex.valid;
   assign io_pipe.ewreg  = r_ex.wreg;
   assign io_pipe.em2reg = r_ex.m2reg;
   assign io_pipe.ewmem  = r_ex.wmem;
   assign io_pipe.ealuc  = r_ex.aluc;
   assign io_pipe.ern    = r_ex.rn;
   assign io_pipe.ea     = r_ex.a;
   assign io_pipe.eb     = r_ex.b;
   assign io_pipe.estore = r_ex.store;

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline stage directly upstream of the 32-bit ALU (ports a, b, aluc).
- Takes decoded fields and register-file read data from ID, resolves operand forwarding and load-use hazards, and registers the ALU operands, ALU control and EX/MEM/WB control bits for the EX stage.
- Drives the pipeline stall to PC and IF/ID, and accepts a squash from branch resolution.

Parameters:
DW, 32, datapath width
RW, 5, register-number width

Ports:
clock  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
id_valid  in  1  ID holds a real instruction
id_qa, id_qb  in  DW  register-file read data for rs, rt
id_rs, id_rt  in  RW  source register numbers
id_use_rs, id_use_rt  in  1  instruction actually reads rs / rt
id_imm  in  DW  extended immediate
id_sa  in  5  shift amount
id_shift  in  1  a <- zero-extended sa instead of rs value
id_aluimm  in  1  b <- imm instead of rt value
id_aluc  in  4  ALU opcode
id_wreg, id_m2reg, id_wmem  in  1  write reg / load / store
id_rn  in  RW  destination register
flush  in  1  squash the ID instruction (taken branch/jump)
ex_result  in  DW  ALU output s of the instruction now in EX
mem_wreg  in  1  MEM-stage instruction writes a register
mem_rn  in  RW  MEM-stage destination
mem_wdata  in  DW  MEM-stage write-back value (ALU or load data, already selected)
stall  out  1  hold PC and IF/ID; combinational
evalid, ewreg, em2reg, ewmem  out  1  EX control
ea, eb  out  DW  ALU operands a, b
ealuc  out  4  ALU aluc
ern  out  RW  EX destination
estore  out  DW  store data (forwarded rt)

Behaviour:
- Reset (sync, at posedge): all outputs are 0. This includes evalid, ealuc=4'b0000 (ADD), ea, eb, estore, ern and all control bits.
- The forwarding source for rs is picked in priority order:
  - EX, if evalid & ewreg & ern!=0 & ern==id_rs; value is ex_result.
  - Else MEM, if mem_wreg & mem_rn!=0 & mem_rn==id_rs; value is mem_wdata.
  - Else id_qa.
  - rt uses the same rule, giving fwd_b from id_qb.
- Register 0 is never forwarded.
- Load-use hazard is raised when:
  - evalid & em2reg & ern!=0, and
  - (id_use_rs & id_rs==ern) | (id_use_rt & id_rt==ern).
- stall = id_valid & hazard & ~flush.
- Operand selection:
  - a = id_shift ? {27'b0,id_sa} : fwd_a.
  - b = id_aluimm ? id_imm : fwd_b.
  - estore = fwd_b.
- Each posedge, when not in reset:
  - If flush | stall | ~id_valid, insert a bubble: evalid, ewreg, em2reg and ewmem are 0, ealuc=0, ea/eb/estore/ern are 0.
  - Otherwise load a, b, estore, id_aluc, id_rn, the control bits, and evalid=1.
- Latency: 1 cycle from ID to EX outputs. A stall lasts exactly 1 cycle per load-use; the next cycle the load is in MEM and is forwarded from mem_wdata.
- flush and hazard in the same cycle: flush wins, stall=0, bubble.
- Reset asserted mid-stall: outputs are zeroed and stall follows the zeroed evalid (0 next cycle).

Optional Feature:
- FWD_EN defined: forwarding as above.
- FWD_EN undefined: fwd_a=id_qa and fwd_b=id_qb, and hazard becomes any RAW match against the EX instruction (evalid & ewreg) or the MEM instruction (mem_wreg), with r0 excluded.
  - stall persists until the producer has written back.
  - ex_result and mem_wdata are unused.

Decomposition:
- Package mips_pipe_pkg holds:
  - DW and RW.
  - ALUC constants: ADD 0000, SUB 0100, AND 0001, OR 0101, XOR 0010, LUI 0110, HAMD 1001, SLL 0011, SRL 0111, SRA 1111.
  - Forward-select enum: FWD_RF, FWD_EX, FWD_MEM.
- Sub-module id_ex_fwd_unit: combinational forward select plus hazard/stall logic. The top level holds the pipeline register.

Test Plan:
1. Reset=1 for 2 cycles with random inputs -> all outputs 0, stall=0.
2. add r3 in EX (ern=3, ewreg=1, ex_result=0x11), ID reads rs=3 with id_qa=0x99 -> ea=0x11 next cycle. With MEM also writing r3 (0x22), EX still wins.
3. Load to r5 in EX (em2reg=1), ID uses rt=5 -> stall=1 for one cycle and a bubble is inserted (evalid=0). Next cycle mem_rn=5, mem_wdata=0xABCD -> eb=0xABCD, estore=0xABCD.
4. Destination r0 in EX and MEM with ID rs=0, id_qa=0 -> ea=0, no stall.
5. flush=1 together with a load-use hazard -> stall=0 and bubble. id_shift=1, sa=7, aluc=SLL -> ea=7, ealuc=0011.
6. FWD_EN undefined, EX writes r4, ID reads r4 -> stall for 2 cycles (EX, then MEM), then ea=id_qa.
